// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one byte-wide SDRAM port between CPU and loader.
// Optional ARB_STATS_EN adds saturating per-requester completion counters.
module sdram_port_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              cpu_wait,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  input  logic              ld_we,
  output logic              ld_full,
  output logic              ld_ovf,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              mem_oe,
  output logic              mem_we,
  input  logic [7:0]        mem_dout,
  input  logic              mem_done,
`ifdef ARB_STATS_EN
  output logic [15:0]       cpu_grants,
  output logic [15:0]       ld_grants,
`endif
  output logic              busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = FIFO_DEPTH[PW:0];
  localparam int EW = ADDR_W + 8;

  typedef enum logic [1:0] {IDLE, CPU_ACC, LD_ACC} state_t;

  state_t            state_q, state_d;
  logic              last_ld_q, last_ld_d;
  logic              req_q;
  logic              cpu_wait_q, cpu_wait_d;
  logic              cpu_we_q, cpu_we_d;
  logic [ADDR_W-1:0] cpu_addr_q, cpu_addr_d;
  logic [7:0]        cpu_din_q, cpu_din_d;
  logic [7:0]        cpu_dout_q, cpu_dout_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_din_q, mem_din_d;
  logic              mem_oe_q, mem_oe_d;
  logic              mem_we_q, mem_we_d;
  logic [EW-1:0]     fifo_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW:0]       cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              cpu_edge, fifo_full, fifo_empty;
  logic              push, pop, cpu_fin, ld_fin;

  assign cpu_edge   = (cpu_rd | cpu_wr) & ~req_q;
  assign fifo_full  = (cnt_q == FULL_CNT);
  assign fifo_empty = (cnt_q == '0);
  assign cpu_fin    = (state_q == CPU_ACC) & mem_done;
  assign ld_fin     = (state_q == LD_ACC) & mem_done;
  assign pop        = ld_fin;
  assign push       = ld_we & (~fifo_full | pop);

  // Loader FIFO bookkeeping; a full push only lands if a pop frees a slot.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q | (ld_we & ~push);
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push & ~pop)      cnt_d = cnt_q + 1'b1;
    else if (pop & ~push) cnt_d = cnt_q - 1'b1;
  end

  // CPU capture, grant selection and access sequencing.
  always_comb begin
    state_d    = state_q;
    last_ld_d  = last_ld_q;
    cpu_wait_d = cpu_wait_q;
    cpu_we_d   = cpu_we_q;
    cpu_addr_d = cpu_addr_q;
    cpu_din_d  = cpu_din_q;
    cpu_dout_d = cpu_dout_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_oe_d   = mem_oe_q;
    mem_we_d   = mem_we_q;
    if (cpu_edge && !cpu_wait_q) begin
      cpu_wait_d = 1'b1;
      cpu_we_d   = cpu_wr;
      cpu_addr_d = cpu_addr;
      cpu_din_d  = cpu_din;
    end
    unique case (state_q)
      IDLE: begin
        if (cpu_wait_q && (fifo_empty || last_ld_q)) begin
          state_d    = CPU_ACC;
          last_ld_d  = 1'b0;
          mem_addr_d = cpu_addr_q;
          mem_din_d  = cpu_din_q;
          mem_oe_d   = ~cpu_we_q;
          mem_we_d   = cpu_we_q;
        end else if (!fifo_empty) begin
          state_d   = LD_ACC;
          last_ld_d = 1'b1;
          {mem_addr_d, mem_din_d} = fifo_q[rd_ptr_q];
          mem_we_d  = 1'b1;
        end
      end
      CPU_ACC: begin
        if (mem_done) begin
          state_d    = IDLE;
          mem_oe_d   = 1'b0;
          mem_we_d   = 1'b0;
          cpu_wait_d = 1'b0;
          if (!cpu_we_q) cpu_dout_d = mem_dout;
        end
      end
      LD_ACC: begin
        if (mem_done) begin
          state_d  = IDLE;
          mem_we_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      last_ld_q  <= 1'b1;
      req_q      <= 1'b0;
      cpu_wait_q <= 1'b0;
      cpu_we_q   <= 1'b0;
      cpu_addr_q <= '0;
      cpu_din_q  <= '0;
      cpu_dout_q <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_oe_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_ld_q  <= last_ld_d;
      req_q      <= cpu_rd | cpu_wr;
      cpu_wait_q <= cpu_wait_d;
      cpu_we_q   <= cpu_we_d;
      cpu_addr_q <= cpu_addr_d;
      cpu_din_q  <= cpu_din_d;
      cpu_dout_q <= cpu_dout_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_oe_q   <= mem_oe_d;
      mem_we_q   <= mem_we_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  // FIFO storage; validity is tracked by the pointers, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= {ld_addr, ld_data};
  end

`ifdef ARB_STATS_EN
  logic [15:0] cpu_cnt_q, cpu_cnt_d, ld_cnt_q, ld_cnt_d;

  // Saturating completion counters.
  always_comb begin
    cpu_cnt_d = cpu_cnt_q;
    ld_cnt_d  = ld_cnt_q;
    if (cpu_fin && cpu_cnt_q != 16'hFFFF) cpu_cnt_d = cpu_cnt_q + 16'd1;
    if (ld_fin && ld_cnt_q != 16'hFFFF)   ld_cnt_d  = ld_cnt_q + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_cnt_q <= '0;
      ld_cnt_q  <= '0;
    end else begin
      cpu_cnt_q <= cpu_cnt_d;
      ld_cnt_q  <= ld_cnt_d;
    end
  end

  assign cpu_grants = cpu_cnt_q;
  assign ld_grants  = ld_cnt_q;
`endif

  assign cpu_dout = cpu_dout_q;
  assign cpu_wait = cpu_wait_q;
  assign ld_full  = fifo_full;
  assign ld_ovf   = ovf_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign mem_oe   = mem_oe_q;
  assign mem_we   = mem_we_q;
  assign busy     = (state_q != IDLE) | ~fifo_empty | cpu_wait_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed bench with a latency-4 SDRAM responder.
// Build with ARB_STATS_EN defined to also exercise the grant counters.
module tb_sdram_port_arbiter;
  localparam int AW  = 17;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] cpu_addr, ld_addr, mem_addr;
  logic          cpu_rd, cpu_wr, cpu_wait, ld_we, ld_full, ld_ovf;
  logic [7:0]    cpu_din, cpu_dout, ld_data, mem_din, mem_dout;
  logic          mem_oe, mem_we, mem_done, busy;
  logic          mdl_done, man_done, hold;
`ifdef ARB_STATS_EN
  logic [15:0]   cpu_grants, ld_grants;
`endif

  int tests = 0;
  int fails = 0;

  logic [AW-1:0] wq_a[$];
  logic [7:0]    wq_d[$];
  int            gaps[$];
  int            oe_cycles;
  int            cyc, mcnt, last_done;
  logic          prev_act, act, d;

  always #5 clk = ~clk;

  assign mem_done = mdl_done | man_done;

  sdram_port_arbiter #(.ADDR_W(AW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_wait(cpu_wait),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_we(ld_we),
    .ld_full(ld_full), .ld_ovf(ld_ovf),
    .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_oe(mem_oe), .mem_we(mem_we),
    .mem_dout(mem_dout), .mem_done(mem_done),
`ifdef ARB_STATS_EN
    .cpu_grants(cpu_grants), .ld_grants(ld_grants),
`endif
    .busy(busy)
  );

  // SDRAM responder: done pulses on the LAT-th cycle an access is held.
  initial begin
    mdl_done = 0; cyc = 0; mcnt = 0; last_done = 0;
    prev_act = 0; oe_cycles = 0;
  end
  always @(posedge clk) begin
    #2;
    cyc++;
    act = mem_oe | mem_we;
    if (act && !prev_act) gaps.push_back(cyc - last_done);
    prev_act = act;
    if (mem_oe) oe_cycles++;
    mdl_done = 0;
    if (act && !hold && !reset) begin
      mcnt++;
      if (mcnt == LAT) begin
        mdl_done = 1;
        mcnt = 0;
        last_done = cyc;
        if (mem_we) begin
          wq_a.push_back(mem_addr);
          wq_d.push_back(mem_din);
        end
      end
    end else begin
      mcnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cpu(output logic dn);
    int n = 0;
    while (cpu_wait && n < 60) begin tick(); n++; end
    dn = mem_done;
    chk("cpu_wait_timeout", {31'd0, cpu_wait}, 0);
  endtask

  task automatic wait_busy(output logic dn);
    int n = 0;
    while (busy && n < 200) begin tick(); n++; end
    dn = mem_done;
    chk("busy_timeout", {31'd0, busy}, 0);
  endtask

  task automatic ld_push(input logic [AW-1:0] a, input logic [7:0] v);
    ld_addr = a; ld_data = v; ld_we = 1; tick(); ld_we = 0;
  endtask

  task automatic cpu_op(input logic [AW-1:0] a, input logic [7:0] v,
                        input logic wr);
    logic dd;
    cpu_addr = a; cpu_din = v; cpu_wr = wr; cpu_rd = ~wr;
    tick();
    cpu_rd = 0; cpu_wr = 0;
    wait_cpu(dd);
    tick();
  endtask

  initial begin
    reset = 1; cpu_addr = 0; cpu_rd = 0; cpu_wr = 0; cpu_din = 0;
    ld_addr = 0; ld_data = 0; ld_we = 0; mem_dout = 8'h5A;
    man_done = 0; hold = 0;
    tick(); tick(); tick();
    chk("rst_cpu_dout", cpu_dout, 0);
    chk("rst_cpu_wait", cpu_wait, 0);
    chk("rst_mem_oe", mem_oe, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ld_full", ld_full, 0);
    chk("rst_ld_ovf", ld_ovf, 0);
    reset = 0;
    tick();

    // CPU read, latency 4
    oe_cycles = 0;
    cpu_addr = 17'h01234; cpu_rd = 1;
    tick();
    chk("rd_wait_set", cpu_wait, 1);
    chk("rd_oe_not_yet", mem_oe, 0);
    tick();
    chk("rd_oe_grant", mem_oe, 1);
    chk("rd_addr", mem_addr, 17'h01234);
    wait_cpu(d);
    chk("rd_wait_after_done", d, 1);
    chk("rd_oe_cycles", oe_cycles, 4);
    chk("rd_dout", cpu_dout, 8'h5A);
    chk("rd_oe_drop", mem_oe, 0);
    chk("rd_ovf", ld_ovf, 0);
    tick(); tick(); tick();
    chk("rd_no_retrigger", cpu_wait, 0);
    cpu_rd = 0;
    tick();

    // three loader writes
    gaps.delete(); wq_a.delete(); wq_d.delete();
    ld_push(17'h00000, 8'h11);
    ld_push(17'h00001, 8'h22);
    ld_push(17'h00002, 8'h33);
    wait_busy(d);
    chk("ld3_busy_at_done", d, 1);
    chk("ld3_count", wq_a.size(), 3);
    chk("ld3_a0", wq_a[0], 17'h00000);
    chk("ld3_d0", wq_d[0], 8'h11);
    chk("ld3_a1", wq_a[1], 17'h00001);
    chk("ld3_d1", wq_d[1], 8'h22);
    chk("ld3_a2", wq_a[2], 17'h00002);
    chk("ld3_d2", wq_d[2], 8'h33);
    chk("ld3_gap1", gaps[1], 2);
    chk("ld3_gap2", gaps[2], 2);
    tick();

    // contention, last grant loader -> CPU first
    wq_a.delete(); wq_d.delete();
    cpu_addr = 17'h10000; cpu_din = 8'hA5; cpu_wr = 1;
    ld_addr = 17'h00100; ld_data = 8'h77; ld_we = 1;
    tick();
    cpu_wr = 0; ld_we = 0;
    wait_busy(d);
    chk("rr1_count", wq_a.size(), 2);
    chk("rr1_first_a", wq_a[0], 17'h10000);
    chk("rr1_first_d", wq_d[0], 8'hA5);
    chk("rr1_second_a", wq_a[1], 17'h00100);
    chk("rr1_second_d", wq_d[1], 8'h77);

    // CPU alone, then contention -> loader first; rd+wr acts as write
    cpu_op(17'h00200, 8'h01, 1'b1);
    wq_a.delete(); wq_d.delete();
    cpu_addr = 17'h00300; cpu_din = 8'h02; cpu_wr = 1; cpu_rd = 1;
    ld_addr = 17'h00400; ld_data = 8'h03; ld_we = 1;
    tick();
    cpu_wr = 0; cpu_rd = 0; ld_we = 0;
    wait_busy(d);
    chk("rr2_count", wq_a.size(), 2);
    chk("rr2_first_a", wq_a[0], 17'h00400);
    chk("rr2_second_a", wq_a[1], 17'h00300);
    chk("rr2_second_d", wq_d[1], 8'h02);
    tick();

    // overflow with mem_done withheld
    hold = 1;
    wq_a.delete(); wq_d.delete();
    ld_push(17'h00020, 8'h40);
    ld_push(17'h00021, 8'h41);
    ld_push(17'h00022, 8'h42);
    chk("ovf_not_full3", ld_full, 0);
    ld_push(17'h00023, 8'h43);
    chk("ovf_full4", ld_full, 1);
    chk("ovf_clear4", ld_ovf, 0);
    ld_push(17'h00024, 8'h44);
    chk("ovf_set5", ld_ovf, 1);
    hold = 0;
    wait_busy(d);
    chk("ovf_writes", wq_a.size(), 4);
    chk("ovf_d0", wq_d[0], 8'h40);
    chk("ovf_d3", wq_d[3], 8'h43);
    chk("ovf_a3", wq_a[3], 17'h00023);
    chk("ovf_full_after", ld_full, 0);
    chk("ovf_sticky", ld_ovf, 1);
    tick();

    // reset during loader access with two queued
    hold = 1;
    wq_a.delete(); wq_d.delete();
    ld_push(17'h00050, 8'h50);
    ld_push(17'h00051, 8'h51);
    ld_push(17'h00052, 8'h52);
    tick();
    chk("mrst_we_active", mem_we, 1);
    reset = 1;
    tick();
    chk("mrst_we", mem_we, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_full", ld_full, 0);
    chk("mrst_ovf", ld_ovf, 0);
    reset = 0; hold = 0;
    man_done = 1;
    tick();
    man_done = 0;
    tick(); tick(); tick();
    chk("late_done_we", mem_we, 0);
    chk("late_done_oe", mem_oe, 0);
    chk("late_done_busy", busy, 0);
    chk("late_done_dout", cpu_dout, 0);
    chk("late_done_writes", wq_a.size(), 0);

`ifdef ARB_STATS_EN
    chk("st_rst_cpu", cpu_grants, 0);
    chk("st_rst_ld", ld_grants, 0);
    cpu_op(17'h00600, 8'h00, 1'b0);
    cpu_op(17'h00601, 8'h61, 1'b1);
    cpu_op(17'h00602, 8'h00, 1'b0);
    ld_push(17'h00700, 8'h70);
    ld_push(17'h00701, 8'h71);
    wait_busy(d);
    chk("st_cpu", cpu_grants, 3);
    chk("st_ld", ld_grants, 2);
    reset = 1;
    tick();
    reset = 0;
    chk("st_clr_cpu", cpu_grants, 0);
    chk("st_clr_ld", ld_grants, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
